bdd_request_controller: RTL and testbench



---
 rtl/bdd_request_controller.sv | 154 +++++++++++++++
 tb/tb_bdd_request_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bdd_request_controller.sv
// BDD accelerator job engine: tags variable-node beats into memory requests,
// collects one result per request, and exposes control/status over Avalon-MM.
module bdd_request_controller #(
  parameter logic [15:0] BASE   = 16'h1000,
  parameter int          DATA_W = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       avs_config_address,
  input  logic              avs_config_write,
  input  logic [31:0]       avs_config_writedata,
  input  logic              avs_config_read,
  output logic [31:0]       avs_config_readdata,
  output logic              avs_config_readdatavalid,
  output logic              avs_config_waitrequest,
  output logic [DATA_W-1:0] aso_cache_data,
  output logic              aso_cache_valid,
  input  logic              aso_cache_ready,
  input  logic [DATA_W-1:0] asi_var_data,
  input  logic              asi_var_valid,
  output logic              asi_var_ready,
  input  logic [DATA_W-1:0] asi_result_data,
  input  logic              asi_result_valid,
  output logic              asi_result_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state, state_next;
  logic        busy, done;
  logic [15:0] req_count, n_reg, issued, results;
  logic [31:0] last_result, checksum, rd_mux;
  logic        in_window, ctrl_wr, start, abort, job_start;
  logic        var_hs, cache_hs, result_hs;
  logic [7:0]  offset;
  logic        unused_bits;

  assign in_window = avs_config_address[15:8] == BASE[15:8];
  assign offset    = avs_config_address[7:0];
  assign ctrl_wr   = avs_config_write && in_window && (offset == 8'd0);
  // Abort dominates a simultaneous start.
  assign abort     = ctrl_wr && avs_config_writedata[1];
  assign start     = ctrl_wr && avs_config_writedata[0] && !abort;
  assign job_start = start && (state == IDLE || state == DONE);

  assign var_hs    = asi_var_valid && asi_var_ready;
  assign cache_hs  = aso_cache_valid && aso_cache_ready;
  assign result_hs = asi_result_valid && asi_result_ready;

  assign avs_config_waitrequest = 1'b0;
  assign unused_bits = ^{avs_config_writedata[31:16], asi_var_data[15:0],
                         asi_result_data[DATA_W-1:32]};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: each always_comb assigns a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) state_next = (req_count == 16'd0) ? DONE : RUN;
        RUN:        if (issued == n_reg) state_next = DRAIN;
        DRAIN:      if (results == n_reg) state_next = DONE;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy             = (state == RUN) || (state == DRAIN);
    done             = (state == DONE);
    asi_var_ready    = (state == RUN) && (issued < n_reg) &&
                       (!aso_cache_valid || aso_cache_ready);
    asi_result_ready = busy && (results < n_reg);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_count   <= '0;
      n_reg       <= '0;
      issued      <= '0;
      results     <= '0;
      last_result <= '0;
      checksum    <= '0;
    end else begin
      if (avs_config_write && in_window && offset == 8'd2)
        req_count <= avs_config_writedata[15:0];
      if (job_start) begin
        n_reg       <= req_count;
        issued      <= '0;
        results     <= '0;
        last_result <= '0;
        checksum    <= '0;
      end else begin
        if (var_hs) issued <= issued + 16'd1;
        if (result_hs) begin
          results     <= results + 16'd1;
          last_result <= asi_result_data[31:0];
          checksum    <= checksum ^ asi_result_data[31:0];
        end
      end
    end
  end

  // Single output register: a new beat may load in the same cycle the
  // pending one is accepted, giving one beat per cycle under ready.
  // NOTE: the wide data register is reset too, so the stream bus reads 0
  // after reset instead of stale X content.
  always_ff @(posedge clk) begin
    if (reset) begin
      aso_cache_data  <= '0;
      aso_cache_valid <= 1'b0;
    end else if (abort) begin
      aso_cache_valid <= 1'b0;
    end else if (var_hs) begin
      aso_cache_data  <= {asi_var_data[DATA_W-1:16], issued};
      aso_cache_valid <= 1'b1;
    end else if (cache_hs) begin
      aso_cache_valid <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (offset)
      8'd1:    rd_mux = {30'd0, done, busy};
      8'd2:    rd_mux = {16'd0, req_count};
      8'd3:    rd_mux = {16'd0, issued};
      8'd4:    rd_mux = {16'd0, results};
      8'd5:    rd_mux = last_result;
      8'd6:    rd_mux = checksum;
      default: rd_mux = '0;
    endcase
  end

  // Shared wired-OR bus: drive zeros whenever not answering.
  always_ff @(posedge clk) begin
    if (reset) begin
      avs_config_readdata      <= '0;
      avs_config_readdatavalid <= 1'b0;
    end else begin
      avs_config_readdatavalid <= avs_config_read && in_window;
      avs_config_readdata      <= (avs_config_read && in_window) ? rd_mux : 32'd0;
    end
  end

endmodule

// File: tb/tb_bdd_request_controller.sv
// Directed bench for bdd_request_controller: config reads, request tagging,
// result collection, backpressure, zero-length jobs, abort and reset.
module tb_bdd_request_controller;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   avs_config_address;
  logic          avs_config_write;
  logic [31:0]   avs_config_writedata;
  logic          avs_config_read;
  logic [31:0]   avs_config_readdata;
  logic          avs_config_readdatavalid;
  logic          avs_config_waitrequest;
  logic [DW-1:0] aso_cache_data;
  logic          aso_cache_valid;
  logic          aso_cache_ready;
  logic [DW-1:0] asi_var_data;
  logic          asi_var_valid;
  logic          asi_var_ready;
  logic [DW-1:0] asi_result_data;
  logic          asi_result_valid;
  logic          asi_result_ready;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  bdd_request_controller #(.BASE(16'h1000), .DATA_W(DW)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .avs_config_address       (avs_config_address),
    .avs_config_write         (avs_config_write),
    .avs_config_writedata     (avs_config_writedata),
    .avs_config_read          (avs_config_read),
    .avs_config_readdata      (avs_config_readdata),
    .avs_config_readdatavalid (avs_config_readdatavalid),
    .avs_config_waitrequest   (avs_config_waitrequest),
    .aso_cache_data           (aso_cache_data),
    .aso_cache_valid          (aso_cache_valid),
    .aso_cache_ready          (aso_cache_ready),
    .asi_var_data             (asi_var_data),
    .asi_var_valid            (asi_var_valid),
    .asi_var_ready            (asi_var_ready),
    .asi_result_data          (asi_result_data),
    .asi_result_valid         (asi_result_valid),
    .asi_result_ready         (asi_result_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] var_beat(input int i);
    return {{31{16'hC0DE ^ 16'(i)}}, 16'hFFFF};
  endfunction

  function automatic logic [DW-1:0] req_beat(input int i);
    return {{31{16'hC0DE ^ 16'(i)}}, 16'(i)};
  endfunction

  task automatic cfg_write(input logic [15:0] addr, input logic [31:0] data);
    avs_config_address   = addr;
    avs_config_writedata = data;
    avs_config_write     = 1'b1;
    @(negedge clk);
    avs_config_write     = 1'b0;
  endtask

  task automatic cfg_read(input logic [15:0] addr, output logic [31:0] data, output logic valid);
    avs_config_address = addr;
    avs_config_read    = 1'b1;
    @(negedge clk);
    avs_config_read    = 1'b0;
    data  = avs_config_readdata;
    valid = avs_config_readdatavalid;
  endtask

  task automatic read_expect(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        v;
    cfg_read(addr, d, v);
    check({tag, "_rdv"}, v, 1'b1);
    check(tag, d, exp);
  endtask

  initial begin
    logic [31:0] rd;
    logic        rv;
    logic [31:0] res_vals [3];
    res_vals = '{32'h11, 32'h22, 32'h44};

    reset = 1'b1;
    avs_config_address = '0; avs_config_write = 1'b0; avs_config_writedata = '0;
    avs_config_read = 1'b0; aso_cache_ready = 1'b0;
    asi_var_data = '0; asi_var_valid = 1'b0; asi_result_data = '0; asi_result_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cache_valid", aso_cache_valid, 1'b0);
    check("rst_cache_data", aso_cache_data, '0);
    check("rst_var_ready", asi_var_ready, 1'b0);
    check("rst_result_ready", asi_result_ready, 1'b0);
    check("rst_rdv", avs_config_readdatavalid, 1'b0);
    check("waitrequest", avs_config_waitrequest, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Reads: in-window one-cycle response, out-of-window silence
    read_expect("status_reset", 16'h1001, 32'd0);
    @(negedge clk);
    check("rdv_single_cycle", avs_config_readdatavalid, 1'b0);
    cfg_read(16'h0000, rd, rv);
    check("outside_rdv", rv, 1'b0);
    check("outside_data", rd, 32'd0);

    // Job of 3 with ready always high
    cfg_write(16'h1002, 32'd3);
    read_expect("req_count", 16'h1002, 32'd3);
    aso_cache_ready = 1'b1;
    cfg_write(16'h1000, 32'd1);
    for (int i = 0; i < 3; i++) begin
      asi_var_data  = var_beat(i);
      asi_var_valid = 1'b1;
      #1 check($sformatf("var_ready_%0d", i), asi_var_ready, 1'b1);
      @(negedge clk);
      check($sformatf("req_valid_%0d", i), aso_cache_valid, 1'b1);
      check($sformatf("req_data_%0d", i), aso_cache_data, req_beat(i));
    end
    asi_var_data = var_beat(3);
    #1 check("fourth_var_refused", asi_var_ready, 1'b0);
    @(negedge clk);
    check("req_valid_clears", aso_cache_valid, 1'b0);
    asi_var_valid = 1'b0;

    for (int i = 0; i < 3; i++) begin
      asi_result_data  = {{15{32'hDEADBEEF}}, res_vals[i]};
      asi_result_valid = 1'b1;
      #1 check($sformatf("result_ready_%0d", i), asi_result_ready, 1'b1);
      @(negedge clk);
    end
    asi_result_valid = 1'b0;
    check("result_ready_full", asi_result_ready, 1'b0);
    @(negedge clk);
    read_expect("status_done", 16'h1001, 32'd2);
    read_expect("issued_3", 16'h1003, 32'd3);
    read_expect("results_3", 16'h1004, 32'd3);
    read_expect("last_result", 16'h1005, 32'h44);
    read_expect("checksum", 16'h1006, 32'h77);
    read_expect("ctrl_reads_0", 16'h1000, 32'd0);
    read_expect("unmapped_0", 16'h1007, 32'd0);

    // Backpressure: one pending beat held for 5 cycles, then 1 beat/cycle
    cfg_write(16'h1002, 32'd4);
    aso_cache_ready = 1'b0;
    cfg_write(16'h1000, 32'd1);
    asi_var_data  = var_beat(0);
    asi_var_valid = 1'b1;
    #1 check("bp_first_ready", asi_var_ready, 1'b1);
    @(negedge clk);
    asi_var_data = var_beat(1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_var_ready_%0d", k), asi_var_ready, 1'b0);
      check($sformatf("bp_data_%0d", k), aso_cache_data, req_beat(0));
      check($sformatf("bp_valid_%0d", k), aso_cache_valid, 1'b1);
      @(negedge clk);
    end
    aso_cache_ready = 1'b1;
    #1 check("bp_release_ready", asi_var_ready, 1'b1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("bp_stream_%0d", i), aso_cache_data, req_beat(i));
      check($sformatf("bp_stream_valid_%0d", i), aso_cache_valid, 1'b1);
      asi_var_data = var_beat(i + 1);
    end
    asi_var_valid = 1'b0;
    @(negedge clk);
    check("bp_drained", aso_cache_valid, 1'b0);
    read_expect("bp_issued", 16'h1003, 32'd4);
    cfg_write(16'h1000, 32'd2);
    read_expect("bp_abort_status", 16'h1001, 32'd0);

    // Zero-length job completes immediately
    cfg_write(16'h1002, 32'd0);
    cfg_write(16'h1000, 32'd1);
    read_expect("zero_status", 16'h1001, 32'd2);
    check("zero_no_request", aso_cache_valid, 1'b0);
    check("zero_var_ready", asi_var_ready, 1'b0);
    read_expect("zero_issued", 16'h1003, 32'd0);

    // Abort mid-RUN with one request pending
    cfg_write(16'h1002, 32'd3);
    aso_cache_ready = 1'b0;
    cfg_write(16'h1000, 32'd1);
    asi_var_data  = var_beat(7);
    asi_var_valid = 1'b1;
    @(negedge clk);
    asi_var_valid = 1'b0;
    check("abort_pending_valid", aso_cache_valid, 1'b1);
    cfg_write(16'h1000, 32'd2);
    check("abort_valid_drop", aso_cache_valid, 1'b0);
    read_expect("abort_status", 16'h1001, 32'd0);
    read_expect("abort_issued_kept", 16'h1003, 32'd1);
    cfg_write(16'h1000, 32'd1);
    read_expect("restart_issued", 16'h1003, 32'd0);
    read_expect("restart_status", 16'h1001, 32'd1);
    check("restart_result_ready", asi_result_ready, 1'b1);
    cfg_write(16'h1000, 32'd3);
    read_expect("start_abort_status", 16'h1001, 32'd0);

    // Reset in the middle of a job
    cfg_write(16'h1000, 32'd1);
    asi_var_data  = var_beat(2);
    asi_var_valid = 1'b1;
    @(negedge clk);
    asi_var_valid = 1'b0;
    check("pre_reset_valid", aso_cache_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_valid", aso_cache_valid, 1'b0);
    check("midreset_data", aso_cache_data, '0);
    check("midreset_var_ready", asi_var_ready, 1'b0);
    check("midreset_result_ready", asi_result_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    read_expect("post_reset_status", 16'h1001, 32'd0);
    read_expect("post_reset_req_count", 16'h1002, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
